// File: rtl/latch_cap_pkg.sv
// latch_cap_pkg: shared types and constants for the latch_q_capture block.
//   cap_state_t      - debounce FSM states
//   EDGE_RISE/FALL   - evt_edge encodings
//   DEF_*            - default parameter values
package latch_cap_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } cap_state_t;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/sync_chain.sv
// sync_chain: SYNC_STAGES-deep flop chain bringing an asynchronous level
// into the clk domain. Flop 0 samples d; q is the last flop.
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset, clears every flop to 0
//   d     - asynchronous input level
//   q     - synchronized level
module sync_chain #(
  parameter int SYNC_STAGES = latch_cap_pkg::DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], d};
  end

  // NOTE: every synchronizer flop is reset so q is a known 0 straight out
  // of reset instead of leaking whatever the chain powered up with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/latch_q_capture.sv
// latch_q_capture: captures the D latch output q_in into the clk domain,
// debounces it and reports each accepted transition as a one-cycle
// rise/fall pulse and as a valid/ready event record.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   q_in                 - latch output (asynchronous)
//   q_sync               - synchronizer output
//   q_stable             - debounced level
//   rise, fall           - one-cycle transition pulses
//   evt_valid, evt_edge  - pending event record (evt_edge 1 = rise)
//   evt_ready            - consumer accepts the pending event
//   ovf, ovf_clr         - sticky dropped-event flag and its clear
//   evt_cnt              - saturating count of accepted transitions
// Configuration: define LATCH_CAP_CNT_EN to build evt_cnt; otherwise it
// is tied to 0.
module latch_q_capture
  import latch_cap_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  output logic             q_sync,
  output logic             q_stable,
  output logic             rise,
  output logic             fall,
  output logic             evt_valid,
  output logic             evt_edge,
  input  logic             evt_ready,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int DB_W = $clog2(STABLE_CYCLES + 1);
  // The accepting sample is the one that would take cnt to STABLE_CYCLES,
  // so the new level is reported on that same edge.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(STABLE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (q_in),
    .q     (q_sync)
  );

  cap_state_t      state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            q_stable_q, q_stable_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            evt_valid_q, evt_valid_d;
  logic            evt_edge_q, evt_edge_d;
  logic            ovf_q, ovf_d;
  logic            new_evt;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    q_stable_d = q_stable_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        if (q_sync) begin
          if (STABLE_CYCLES == 1) begin
            state_d    = IDLE_HI;
            q_stable_d = 1'b1;
            rise_d     = 1'b1;
            db_cnt_d   = '0;
          end else begin
            state_d  = CHK_HI;
            db_cnt_d = DB_ONE;
          end
        end
      end
      CHK_HI: begin
        if (!q_sync) begin
          state_d  = IDLE_LO;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = IDLE_HI;
          q_stable_d = 1'b1;
          rise_d     = 1'b1;
          db_cnt_d   = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      IDLE_HI: begin
        if (!q_sync) begin
          if (STABLE_CYCLES == 1) begin
            state_d    = IDLE_LO;
            q_stable_d = 1'b0;
            fall_d     = 1'b1;
            db_cnt_d   = '0;
          end else begin
            state_d  = CHK_LO;
            db_cnt_d = DB_ONE;
          end
        end
      end
      CHK_LO: begin
        if (q_sync) begin
          state_d  = IDLE_HI;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = IDLE_LO;
          q_stable_d = 1'b0;
          fall_d     = 1'b1;
          db_cnt_d   = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d  = IDLE_LO;
        db_cnt_d = '0;
      end
    endcase
  end

  assign new_evt = rise_d | fall_d;

  // Event record: a new event may replace one being handed off this edge,
  // but one arriving onto an unaccepted record is dropped. ovf set beats
  // ovf_clr because the clear is applied first and the set after it.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_edge_d  = evt_edge_q;
    ovf_d       = ovf_q & ~ovf_clr;
    if (new_evt) begin
      if (evt_valid_q && !evt_ready) begin
        ovf_d = 1'b1;
      end else begin
        evt_valid_d = 1'b1;
        evt_edge_d  = rise_d ? EDGE_RISE : EDGE_FALL;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE_LO;
      db_cnt_q    <= '0;
      q_stable_q  <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_edge_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      q_stable_q  <= q_stable_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      evt_valid_q <= evt_valid_d;
      evt_edge_q  <= evt_edge_d;
      ovf_q       <= ovf_d;
    end
  end

  assign q_stable  = q_stable_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign evt_valid = evt_valid_q;
  assign evt_edge  = evt_edge_q;
  assign ovf       = ovf_q;

`ifdef LATCH_CAP_CNT_EN
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;

  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (new_evt && (evt_cnt_q != '1)) begin
      evt_cnt_d = evt_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt_q <= '0;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign evt_cnt = evt_cnt_q;
`else
  assign evt_cnt = '0;
`endif

endmodule

// File: tb/tb_latch_q_capture.sv
// tb_latch_q_capture: directed scenarios plus randomized q_in/evt_ready/
// ovf_clr traffic, checked every cycle against a run-length model of the
// debounce and a one-entry event record. Two instances run side by side:
// default parameters and CNT_W = 2 for counter saturation.
module tb_latch_q_capture;
  import latch_cap_pkg::*;

  localparam int SS = DEF_SYNC_STAGES;
  localparam int SC = DEF_STABLE_CYCLES;
`ifdef LATCH_CAP_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic q_in = 1'b0;
  logic evt_ready = 1'b0;
  logic ovf_clr = 1'b0;

  logic       q_sync_a, q_stable_a, rise_a, fall_a, evt_valid_a, evt_edge_a, ovf_a;
  logic [7:0] evt_cnt_a;
  logic       q_sync_b, q_stable_b, rise_b, fall_b, evt_valid_b, evt_edge_b, ovf_b;
  logic [1:0] evt_cnt_b;

  always #5 clk = ~clk;

  latch_q_capture dut_a (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .q_sync(q_sync_a), .q_stable(q_stable_a),
    .rise(rise_a), .fall(fall_a), .evt_valid(evt_valid_a), .evt_edge(evt_edge_a),
    .evt_ready(evt_ready), .ovf(ovf_a), .ovf_clr(ovf_clr), .evt_cnt(evt_cnt_a)
  );

  latch_q_capture #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .q_sync(q_sync_b), .q_stable(q_stable_b),
    .rise(rise_b), .fall(fall_b), .evt_valid(evt_valid_b), .evt_edge(evt_edge_b),
    .evt_ready(evt_ready), .ovf(ovf_b), .ovf_clr(ovf_clr), .evt_cnt(evt_cnt_b)
  );

  int n_checks = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: q_in delayed SS samples, a run length of samples that
  // disagree with the accepted level, and a single-slot event record.
  bit m_hist[SS];
  bit m_stable, m_rise, m_fall, m_valid, m_edge, m_ovf;
  int m_run, m_events;

  function automatic int exp_cnt(input int w);
    int lim;
    int v;
    lim = (1 << w) - 1;
    v = (m_events > lim) ? lim : m_events;
    if (!CNT_ON) v = 0;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SS; i++) m_hist[i] = 1'b0;
    m_stable = 0; m_rise = 0; m_fall = 0; m_valid = 0; m_edge = 0; m_ovf = 0;
    m_run = 0; m_events = 0;
  endtask

  task automatic model_edge();
    bit qs;
    qs = m_hist[SS-1];
    m_rise = 0;
    m_fall = 0;
    if (qs != m_stable) begin
      m_run++;
      if (m_run == SC) begin
        m_stable = qs;
        m_rise = qs;
        m_fall = !qs;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    if (ovf_clr) m_ovf = 0;
    if (m_rise || m_fall) begin
      m_events++;
      if (m_valid && !evt_ready) m_ovf = 1;
      else begin
        m_valid = 1;
        m_edge = m_rise;
      end
    end else if (m_valid && evt_ready) begin
      m_valid = 0;
    end
    for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = q_in;
  endtask

  task automatic check_all();
    check("q_sync_a", q_sync_a, m_hist[SS-1]);
    check("q_stable_a", q_stable_a, m_stable);
    check("rise_a", rise_a, m_rise);
    check("fall_a", fall_a, m_fall);
    check("evt_valid_a", evt_valid_a, m_valid);
    check("evt_edge_a", evt_edge_a, m_edge);
    check("ovf_a", ovf_a, m_ovf);
    check("evt_cnt_a", evt_cnt_a, exp_cnt(8));
    check("q_stable_b", q_stable_b, m_stable);
    check("rise_b", rise_b, m_rise);
    check("fall_b", fall_b, m_fall);
    check("evt_valid_b", evt_valid_b, m_valid);
    check("evt_edge_b", evt_edge_b, m_edge);
    check("ovf_b", ovf_b, m_ovf);
    check("q_sync_b", q_sync_b, m_hist[SS-1]);
    check("evt_cnt_b", evt_cnt_b, exp_cnt(2));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".q_sync"}, q_sync_a, 0);
    check({tag, ".q_stable"}, q_stable_a, 0);
    check({tag, ".rise"}, rise_a, 0);
    check({tag, ".fall"}, fall_a, 0);
    check({tag, ".evt_valid"}, evt_valid_a, 0);
    check({tag, ".evt_edge"}, evt_edge_a, 0);
    check({tag, ".ovf"}, ovf_a, 0);
    check({tag, ".evt_cnt"}, evt_cnt_a, 0);
    check({tag, ".evt_cnt_b"}, evt_cnt_b, 0);
  endtask

  // One clock: model follows the edge, outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First rise: reported on edge 6 after q_in goes high.
    q_in = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e < 6) check("rise_early", rise_a, 0);
    end
    check("rise_edge6", rise_a, 1);
    check("evt_valid_edge6", evt_valid_a, 1);
    check("evt_edge_rise", evt_edge_a, EDGE_RISE);
    check("q_stable_hi", q_stable_a, 1);
    check("evt_cnt_first", evt_cnt_a, CNT_ON ? 1 : 0);
    step();
    check("rise_one_cycle", rise_a, 0);
    evt_ready = 1'b1; step(); evt_ready = 1'b0;
    check("evt_valid_consumed", evt_valid_a, 0);

    // Return low and consume the fall.
    q_in = 1'b0; steps(10);
    evt_ready = 1'b1; step(); evt_ready = 1'b0;

    // Bounce: high for 3 cycles only.
    q_in = 1'b1; steps(3);
    q_in = 1'b0; steps(8);
    check("bounce_q_stable", q_stable_a, 0);
    check("bounce_no_evt", evt_valid_a, 0);
    check("bounce_cnt", evt_cnt_a, CNT_ON ? 2 : 0);

    // Overflow: rise held unaccepted, then a fall arrives.
    q_in = 1'b1; steps(10);
    q_in = 1'b0; steps(10);
    check("ovf_keep_valid", evt_valid_a, 1);
    check("ovf_keep_edge", evt_edge_a, EDGE_RISE);
    check("ovf_set", ovf_a, 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_cleared", ovf_a, 0);

    // Handshake on the same edge a new fall loads.
    evt_ready = 1'b1; step(); evt_ready = 1'b0;
    q_in = 1'b1; steps(10);
    q_in = 1'b0; steps(5);
    evt_ready = 1'b1; step(); evt_ready = 1'b0;
    check("same_edge_fall", fall_a, 1);
    check("same_edge_valid", evt_valid_a, 1);
    check("same_edge_edge", evt_edge_a, EDGE_FALL);
    check("same_edge_ovf", ovf_a, 0);
    check("sat_cnt_b", evt_cnt_b, CNT_ON ? 3 : 0);
    evt_ready = 1'b1; step(); evt_ready = 1'b0;

    // Reset during CHK_HI with q_in held high.
    q_in = 1'b1; steps(4);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("midreset");
    steps(2);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e < 6) check("rst_rise_early", rise_a, 0);
    end
    check("rst_rise_edge6", rise_a, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) q_in = ~q_in;
      evt_ready = ($urandom_range(0, 2) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
